// File: rtl/rv_fetch_pkg.sv
// Shared fetch/decode definitions: halfword type, instruction sizes, the
// compressed-instruction test and the fetch request FSM states.
package rv_fetch_pkg;

  typedef logic [15:0] hw_t;

  localparam logic [2:0] ISIZE_C = 3'd2;
  localparam logic [2:0] ISIZE_W = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  // Low two bits of 2'b11 mark a 32-bit instruction; anything else is RVC.
  function automatic logic is_compressed(input hw_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/hw_fifo.sv
// Halfword FIFO with up to two pushes and two pops per cycle; exposes the two
// oldest entries and the fill level. Synchronous flush, asynchronous reset.
module hw_fifo
  import rv_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  hw_t           push_hw0,
  input  hw_t           push_hw1,
  input  logic [1:0]    pop_n,
  output hw_t           head_hw0,
  output hw_t           head_hw1,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  hw_t           mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] rd_ptr1, wr_ptr1;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign rd_ptr1  = rd_ptr + AW'(1);
  assign wr_ptr1  = wr_ptr + AW'(1);
  assign head_hw0 = mem[rd_ptr];
  assign head_hw1 = mem[rd_ptr1];

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // NOTE: the storage array has no reset; entries are only visible through
  // count, so clearing the pointers is enough and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr]  <= push_hw0;
    if (push_n == 2'd2) mem[wr_ptr1] <= push_hw1;
  end

endmodule

// File: rtl/instr_fetch_align.sv
// Instruction fetch and RVC re-alignment: one word request in flight, returned
// halfwords buffered, one 16- or 32-bit instruction presented per handshake.
module instr_fetch_align
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [2:0]  instr_size,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  localparam int CW = $clog2(BUF_HW) + 1;

  fetch_state_e  state, state_next;
  logic [31:0]   fetch_addr, out_pc;
  logic          drop, skip_low, redir_q, misalign_q;
  logic [CW-1:0] count, count_next;
  hw_t           hw0, hw1, push_hw0, push_hw1;
  logic [1:0]    push_n, pop_n;
  logic          gnt_ok, rv_take, fire, head_c, avail, free_ok;
  logic [2:0]    head_size;

  hw_fifo #(.DEPTH(BUF_HW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push_n   (push_n),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .pop_n    (pop_n),
    .head_hw0 (hw0),
    .head_hw1 (hw1),
    .count    (count)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves a value unassigned and infers a latch.
    push_n   = 2'd0;
    push_hw0 = imem_rdata[15:0];
    push_hw1 = imem_rdata[31:16];
    head_c    = is_compressed(hw0);
    head_size = head_c ? ISIZE_C : ISIZE_W;
    avail     = (count >= CW'(2)) || ((count != '0) && head_c);
    gnt_ok    = imem_req && imem_gnt;
    rv_take   = imem_rvalid && (state == WAIT) && !drop && !redirect_valid;
    if (rv_take) begin
      push_n = skip_low ? 2'd1 : 2'd2;
      if (skip_low) push_hw0 = imem_rdata[31:16];
    end
    fire       = avail && instr_ready && !redirect_valid;
    pop_n      = fire ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    count_next = redirect_valid ? '0 : count + CW'(push_n) - CW'(pop_n);
    free_ok    = count_next <= CW'(BUF_HW - 2);
  end

  // A redirect empties the buffer, so free_ok alone pulls IDLE into REQ.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (free_ok) state_next = REQ;
      REQ:     if (gnt_ok) state_next = WAIT;
      WAIT:    if (imem_rvalid) state_next = free_ok ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_addr <= RESET_PC & ~32'h3;
      out_pc     <= RESET_PC;
      drop       <= 1'b0;
      skip_low   <= RESET_PC[1];
      redir_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_next;
      redir_q    <= redirect_valid;
      misalign_q <= redirect_valid && redirect_pc[0];
      if (redirect_valid) begin
        fetch_addr <= {redirect_pc[31:2], 2'b00};
        out_pc     <= {redirect_pc[31:1], 1'b0};
        skip_low   <= redirect_pc[1];
        // The in-flight word (if any) belongs to the old stream.
        drop       <= gnt_ok || ((state == WAIT) && !imem_rvalid);
      end else begin
        if (gnt_ok)  fetch_addr <= fetch_addr + 32'd4;
        if (fire)    out_pc     <= out_pc + 32'(head_size);
        if (rv_take) skip_low   <= 1'b0;
        if ((state == WAIT) && imem_rvalid && drop) drop <= 1'b0;
      end
    end
  end

  // Requests pause for the cycle after a redirect so the address can change.
  assign imem_req     = (state == REQ) && !redir_q;
  assign imem_addr    = imem_req ? fetch_addr : '0;
  assign instr_valid  = avail;
  assign instr_data   = !avail ? '0 : (head_c ? {16'h0000, hw0} : {hw1, hw0});
  assign instr_pc     = avail ? out_pc : '0;
  assign instr_size   = avail ? head_size : '0;
  assign misalign_err = misalign_q;

  a_rvalid_room: assert property (@(posedge clk) disable iff (reset)
    (imem_rvalid && !drop) |-> (count <= CW'(BUF_HW - 2)));
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (state == WAIT));

endmodule

// File: tb/tb_instr_fetch_align.sv
// Self-checking bench for instr_fetch_align: memory responder, a pc-driven
// instruction-stream model, directed scenarios and a randomized run.
module tb_instr_fetch_align;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic [2:0]  instr_size;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  instr_fetch_align #(.RESET_PC(32'h0), .BUF_HW(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_size     (instr_size),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [2:0]  size;
  } ent_t;

  logic [31:0] mem [64];
  ent_t        log_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          gnt_pct  = 100;
  int          lat_lo   = 0;
  int          lat_hi   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction the decoder must see at pc, from the RVC encoding rule alone.
  task automatic model(input logic [31:0] pc, output logic [31:0] d, output logic [2:0] s);
    logic [15:0] lo;
    lo = hw_at(pc);
    if (lo[1:0] != 2'b11) begin
      d = {16'h0000, lo};
      s = 3'd2;
    end else begin
      d = {hw_at(pc + 32'd2), lo};
      s = 3'd4;
    end
  endtask

  // Instruction memory: grants at gnt_pct, answers after lat_lo..lat_hi cycles.
  initial begin
    logic        hs, pending;
    logic [31:0] haddr, paddr;
    int          dly;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pending = 1'b0; paddr = '0; dly = 0;
    forever begin
      @(negedge clk);
      hs    = imem_req && imem_gnt;
      haddr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (reset) begin
        pending  = 1'b0;
        imem_gnt = 1'b0;
        continue;
      end
      if (hs) begin
        pending = 1'b1;
        paddr   = haddr;
        dly     = lat_lo + int'($urandom_range(lat_hi - lat_lo, 0));
      end
      if (pending) begin
        if (dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem[paddr[7:2]];
          pending     = 1'b0;
        end else begin
          dly--;
        end
      end
      imem_gnt = imem_req && (int'($urandom_range(99, 0)) < gnt_pct);
    end
  end

  // Compare process: every cycle out of reset, outputs against the stream model.
  initial begin
    logic [31:0] exp_pc, e_data, p_addr;
    logic [2:0]  e_size;
    logic        exp_mis, p_valid, p_ready, p_redir, p_req, p_gnt, fire;
    int          idle;
    exp_pc = '0; e_data = '0; e_size = '0; p_addr = '0; exp_mis = 1'b0;
    p_valid = 1'b0; p_ready = 1'b0; p_redir = 1'b0; p_req = 1'b0; p_gnt = 1'b0;
    idle = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_pc = 32'h0; exp_mis = 1'b0; idle = 0;
        p_valid = 1'b0; p_redir = 1'b0; p_req = 1'b0;
        continue;
      end
      e_size = '0;
      if (instr_valid) begin
        model(exp_pc, e_data, e_size);
        check("instr_data", instr_data, e_data);
        check("instr_pc", instr_pc, exp_pc);
        check("instr_size", 32'(instr_size), 32'(e_size));
      end
      if (p_redir) check("valid_after_redirect", 32'(instr_valid), 32'd0);
      check("misalign_err", 32'(misalign_err), 32'(exp_mis));
      if (p_valid && !p_ready && !p_redir) check("hold_valid", 32'(instr_valid), 32'd1);
      if (p_req && !p_gnt && !p_redir) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", imem_addr, p_addr);
      end
      if (imem_req) check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
      fire = instr_valid && instr_ready && !redirect_valid;
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:1], 1'b0};
      end else if (fire) begin
        log_q.push_back('{instr_data, instr_pc, instr_size});
        exp_pc = exp_pc + 32'(e_size);
      end
      exp_mis = redirect_valid && redirect_pc[0];
      if (!instr_ready || fire || redirect_valid) idle = 0;
      else idle++;
      if (idle >= 100) begin
        n_checks++; n_fail++;
        $display("FAIL liveness: no instruction for %0d ready cycles, expected progress", idle);
        idle = 0;
      end
      p_valid = instr_valid; p_ready = instr_ready; p_redir = redirect_valid;
      p_req = imem_req; p_gnt = imem_gnt; p_addr = imem_addr;
    end
  end

  task automatic wait_fire(input int n, input string name);
    int k;
    k = 0;
    while (log_q.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (log_q.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL %s: saw %0d instructions, expected %0d", name, log_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_ent(input int i, input string name, input logic [31:0] d,
                           input logic [31:0] pc, input logic [2:0] s);
    ent_t e;
    e = (i < log_q.size()) ? log_q[i] : '{32'hx, 32'hx, 3'hx};
    check({name, "_data"}, e.data, d);
    check({name, "_pc"}, e.pc, pc);
    check({name, "_size"}, 32'(e.size), 32'(s));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 32'(instr_valid), 32'd0);
    check({name, "_data"}, instr_data, 32'd0);
    check({name, "_pc"}, instr_pc, 32'd0);
    check({name, "_size"}, 32'(instr_size), 32'd0);
    check({name, "_req"}, 32'(imem_req), 32'd0);
    check({name, "_addr"}, imem_addr, 32'd0);
    check({name, "_mis"}, 32'(misalign_err), 32'd0);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    log_q.delete();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0045_0513;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #2 reset = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("req_after_reset", 32'(imem_req), 32'd1);
    check("addr_after_reset", imem_addr, 32'd0);

    // A single 32-bit instruction at pc 0.
    wait_fire(1, "t1");
    check_ent(0, "t1", 32'h0045_0513, 32'h0, 3'd4);

    // Reset asserted while a request waits for its grant.
    gnt_pct = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!imem_req && k < 50);
    check("t6_in_req", 32'(imem_req), 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_all_zero("t6_reset");
    mem[0] = 32'h0513_0001;
    mem[1] = 32'h0001_0045;
    log_q.delete();
    gnt_pct = 100;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Mixed stream across a word boundary.
    wait_fire(3, "t2");
    check_ent(0, "t2a", 32'h0000_0001, 32'h0, 3'd2);
    check_ent(1, "t2b", 32'h0045_0513, 32'h2, 3'd4);
    check_ent(2, "t2c", 32'h0000_0001, 32'h6, 3'd2);

    // Redirect while a read is outstanding: the stale word must be dropped.
    lat_lo = 3; lat_hi = 3;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(imem_req && imem_gnt) && k < 50);
    @(posedge clk);
    #1;
    pulse_redirect(32'h6);
    wait_fire(1, "t3");
    check_ent(0, "t3", 32'h0000_0001, 32'h6, 3'd2);

    // Decoder stalls: the buffer fills and fetching pauses.
    lat_lo = 0; lat_hi = 0;
    instr_ready = 1'b0;
    pulse_redirect(32'h0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_req_idle", 32'(imem_req), 32'd0);
    check("t4_valid", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #1 instr_ready = 1'b1;
    wait_fire(3, "t4");
    check_ent(0, "t4a", 32'h0000_0001, 32'h0, 3'd2);
    check_ent(1, "t4b", 32'h0045_0513, 32'h2, 3'd4);
    check_ent(2, "t4c", 32'h0000_0001, 32'h6, 3'd2);

    // Odd redirect target.
    pulse_redirect(32'h5);
    @(negedge clk);
    check("t5_mis_pulse", 32'(misalign_err), 32'd1);
    @(negedge clk);
    check("t5_mis_clear", 32'(misalign_err), 32'd0);
    wait_fire(1, "t5");
    check_ent(0, "t5", 32'h0000_0045, 32'h4, 3'd2);

    // Randomized run on fresh memory.
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
    gnt_pct = 70; lat_lo = 0; lat_hi = 3;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      instr_ready    = (i % 500 < 20) ? 1'b0 : (int'($urandom_range(99, 0)) < 80);
      redirect_valid = int'($urandom_range(99, 0)) < 3;
      redirect_pc    = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                   : ($urandom & 32'hFF);
    end
    redirect_valid = 1'b0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
